// File: rtl/store_buffer.sv
// Posted-write store buffer: an in-order FIFO of stores that drains into the
// data memory write port, with a stall for loads that overlap queued stores.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [2:0]       st_funct3,
  output logic             st_ready,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [2:0]       ld_funct3,
  output logic             ld_stall,
  output logic             mem_write,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_writeData,
  output logic [2:0]       mem_funct3,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [2:0]       f3_q   [DEPTH];
  logic [2:0]       f3_d   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [PTR_W-1:0] offs;
  logic [DEPTH-1:0] entry_valid, entry_hit;
  logic [32:0]      ld_hi;
  logic             unused_ld_sign;

  // Last byte of an access, in 33 bits so the top-of-memory span does not wrap.
  function automatic logic [32:0] span_hi(input logic [31:0] addr, input logic [1:0] sz);
    logic [32:0] last;
    case (sz)
      2'b00:   last = 33'd0;
      2'b01:   last = 33'd1;
      default: last = 33'd3;
    endcase
    return {1'b0, addr} + last;
  endfunction

  assign unused_ld_sign = ld_funct3[2];
  assign ld_hi          = span_hi(ld_addr, ld_funct3[1:0]);

  // Overlap of the load span against every occupied entry.
  always_comb begin
    offs        = '0;
    entry_valid = '0;
    entry_hit   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs           = PTR_W'(i) - rd_ptr_q;
      entry_valid[i] = CNT_W'(offs) < count_q;
      entry_hit[i]   = entry_valid[i]
                     && ({1'b0, ld_addr} <= span_hi(addr_q[i], f3_q[i][1:0]))
                     && ({1'b0, addr_q[i]} <= ld_hi);
    end
  end

  assign st_ready  = (count_q != CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign ld_stall  = ld_valid & (|entry_hit);
  // A stalled load yields the port so the conflicting stores can drain.
  assign mem_write = ~empty & (~ld_valid | ld_stall);
  assign push      = st_valid & st_ready;
  assign pop       = mem_write;

  assign mem_address   = empty ? 32'd0 : addr_q[rd_ptr_q];
  assign mem_writeData = empty ? 32'd0 : data_q[rd_ptr_q];
  assign mem_funct3    = empty ? 3'd0  : f3_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    f3_d   = f3_q;
    if (push) begin
      addr_d[wr_ptr_q] = st_addr;
      data_d[wr_ptr_q] = st_data;
      f3_d[wr_ptr_q]   = st_funct3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    f3_q   <= f3_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected memory writes are queued at issue
// time and a negedge monitor pops and compares each drained store.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             st_valid, ld_valid, st_ready, ld_stall, mem_write, empty;
  logic [31:0]      st_addr, st_data, ld_addr, mem_address, mem_writeData;
  logic [2:0]       st_funct3, ld_funct3, mem_funct3;
  logic [CNT_W-1:0] count;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
  } st_t;

  st_t exp_q[$];
  st_t mon_e;
  int  total = 0;
  int  bad   = 0;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3), .ld_stall(ld_stall),
    .mem_write(mem_write), .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_funct3(mem_funct3), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every memory write must match the oldest expected store.
  always @(negedge clk) begin
    if (rst && mem_write) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=0x%08h want no write", mem_address);
      end else begin
        mon_e = exp_q.pop_front();
        chk("drain_addr", mem_address, mon_e.a);
        chk("drain_data", mem_writeData, mon_e.d);
        chk("drain_funct3", 32'(mem_funct3), 32'(mon_e.f));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f;
    exp_q.push_back({a, d, f});
    tick();
    st_valid  = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f);
    ld_valid  = 1'b1;
    ld_addr   = a;
    ld_funct3 = f;
  endtask

  initial begin
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    at_neg();
    rst = 1'b1;
    tick();

    // Single word store drains the next cycle.
    push_st(32'h10, 32'hDEADBEEF, 3'b010);
    at_neg();
    chk("sw_count", 32'(count), 32'd1);
    chk("sw_mem_write", 32'(mem_write), 32'd1);
    tick();
    at_neg();
    chk("sw_empty_after", 32'(empty), 32'd1);
    chk("sw_idle_write", 32'(mem_write), 32'd0);

    // Fill while a non-overlapping load owns the port.
    tick();
    load(32'h40, 3'b010);
    for (int i = 0; i < 4; i++) push_st(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 3'b010);
    st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h55; st_funct3 = 3'b010;
    at_neg();
    chk("full_st_ready", 32'(st_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ld_stall", 32'(ld_stall), 32'd0);
    chk("full_mem_write", 32'(mem_write), 32'd0);
    tick();
    st_valid = 1'b0;
    at_neg();
    chk("full_reject_count", 32'(count), 32'd4);
    tick();
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("drain_count", 32'(count), 32'(4 - i));
      tick();
    end
    at_neg();
    chk("fill_drained_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-operation discards queued stores.
    tick();
    load(32'h40, 3'b010);
    for (int i = 0; i < 3; i++) push_st(32'h300 + 32'(4 * i), 32'hC000_0000 + 32'(i), 3'b010);
    at_neg();
    chk("pre_rst_count", 32'(count), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_mem_write", 32'(mem_write), 32'd0);
    chk("midrst_st_ready", 32'(st_ready), 32'd1);
    chk("midrst_ld_stall", 32'(ld_stall), 32'd0);
    exp_q.delete();
    #1;
    rst = 1'b1;
    ld_valid = 1'b0;
    tick();

    // Byte store at 0x23 overlaps a word load at 0x20.
    push_st(32'h23, 32'h0000_00AB, 3'b000);
    load(32'h20, 3'b010);
    at_neg();
    chk("ovl_stall", 32'(ld_stall), 32'd1);
    chk("ovl_mem_write", 32'(mem_write), 32'd1);
    tick();
    at_neg();
    chk("ovl_stall_clear", 32'(ld_stall), 32'd0);
    chk("ovl_write_clear", 32'(mem_write), 32'd0);
    tick();
    ld_valid = 1'b0;

    // Word load at 0x24 does not overlap and owns the port.
    push_st(32'h23, 32'h0000_00CD, 3'b000);
    load(32'h24, 3'b010);
    at_neg();
    chk("nolap_stall", 32'(ld_stall), 32'd0);
    chk("nolap_mem_write", 32'(mem_write), 32'd0);
    chk("nolap_count", 32'(count), 32'd1);
    tick();
    ld_valid = 1'b0;
    at_neg();
    tick();

    // Halfword at 0x31 covers 0x31..0x32 only.
    push_st(32'h31, 32'h0000_1234, 3'b001);
    load(32'h33, 3'b100);
    at_neg();
    chk("half_lbu33_stall", 32'(ld_stall), 32'd0);
    chk("half_lbu33_write", 32'(mem_write), 32'd0);
    tick();
    load(32'h32, 3'b000);
    at_neg();
    chk("half_lb32_stall", 32'(ld_stall), 32'd1);
    chk("half_lb32_write", 32'(mem_write), 32'd1);
    tick();
    ld_valid = 1'b0;
    at_neg();
    chk("half_empty", 32'(empty), 32'd1);

    // Streaming push with concurrent drain wraps the pointers.
    for (int i = 0; i < 6; i++) begin
      push_st(32'h500 + 32'(4 * i), 32'hB000_0000 + 32'(i), 3'(i % 3));
      at_neg();
      chk("stream_count", 32'(count), 32'd1);
    end
    tick();
    at_neg();
    chk("stream_empty", 32'(empty), 32'd1);

    // Top-of-memory span does not wrap onto address 0.
    tick();
    push_st(32'hFFFF_FFFE, 32'h1122_3344, 3'b010);
    load(32'h0, 3'b010);
    at_neg();
    chk("top_lw0_stall", 32'(ld_stall), 32'd0);
    chk("top_lw0_write", 32'(mem_write), 32'd0);
    tick();
    load(32'hFFFF_FFFF, 3'b000);
    at_neg();
    chk("top_lbff_stall", 32'(ld_stall), 32'd1);
    tick();
    ld_valid = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    at_neg();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("final_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the execute stage and the byte-addressed data memory.
- Accepts stores from the pipeline in one cycle, queues them in order, and drains one store per cycle into the data memory write port whenever the port is not needed by a load.
- A load whose bytes overlap any queued store is stalled until the conflicting stores have drained, so memory reads always return program-order data.

Parameters:
DEPTH, 4, number of store entries; power of two, 2..16
PTR_W, 2, log2(DEPTH); pointer width
CNT_W, 3, PTR_W+1; occupancy counter width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset; clears the buffer
st_valid  in  1  store request from execute stage
st_addr  in  32  store byte address
st_data  in  32  store data; low bytes used for sb/sh
st_funct3  in  3  store size: 000 sb, 001 sh, 010 sw
st_ready  out  1  buffer can accept a store this cycle
ld_valid  in  1  load request presented to data memory this cycle
ld_addr  in  32  load byte address
ld_funct3  in  3  load size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
ld_stall  out  1  load overlaps a queued store; pipeline must hold the load
mem_write  out  1  data memory write enable
mem_address  out  32  data memory address (head entry)
mem_writeData  out  32  data memory write data (head entry)
mem_funct3  out  3  store size to data memory (packed into inst[14:12] by integrator)
count  out  CNT_W  number of valid entries
empty  out  1  count == 0

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr[31:0], data[31:0], funct3[2:0]}; wr_ptr, rd_ptr (PTR_W), count (CNT_W). Pointers wrap DEPTH-1 -> 0.
- Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0; outputs immediately st_ready=1, empty=1, mem_write=0, ld_stall=0. Entry contents are don't-care. Stores queued before a mid-operation reset are discarded.
- mem_address, mem_writeData and mem_funct3 are combinational from the head entry. They are 0 when empty.
- Push: accept when st_valid & st_ready, where st_ready = (count != DEPTH) from registered state. The entry is written at wr_ptr on the rising edge and wr_ptr increments. funct3 is stored unchecked; undefined sizes are drained unchanged.
- Overlap check:
  - Byte span size from funct3[1:0]: 00=1, 01=2, 10=4 (11 treated as 4).
  - Spans are [addr, addr+size-1], computed in 33 bits so a span at 0xFFFFFFFD does not wrap to 0.
  - Two spans overlap iff lo_a <= hi_b and lo_b <= hi_a.
- ld_stall = ld_valid & (overlap with any valid entry). Comparison is against registered entries only; a store pushed in the same cycle is not compared.
- Drain: mem_write = ~empty & (~ld_valid | ld_stall).
  - A non-conflicting load owns the memory port and draining pauses.
  - A stalled load yields the port, so the buffer drains and the stall clears without deadlock.
  - When mem_write=1, the head is written by data memory on the same rising edge; rd_ptr increments.
- Latency: a store accepted at edge N can be written to memory at edge N+1 at the earliest. Drain rate is 1 store/cycle.
- Push and drain in the same cycle: both occur and count is unchanged.
  - A full buffer with a drain in the same cycle still reports st_ready=0 (registered full, no bypass).
  - An empty buffer with a push does not drain that entry until the next cycle.
- count updates +1 on push only, -1 on drain only, 0 on both or neither.
- empty = (count == 0).
- Ordering: stores reach memory in acceptance order, and a later store to the same address overwrites.

Test Plan:
- Reset: drive rst=0 mid-operation with count=3 -> count=0, empty=1, mem_write=0, st_ready=1 without a clock edge.
- Single sw: push addr=0x10, data=0xDEADBEEF, funct3=010, with ld_valid=0 -> next cycle mem_write=1, mem_address=0x10, mem_writeData=0xDEADBEEF, mem_funct3=010; then empty=1.
- Fill: hold ld_valid=1 (non-overlapping, addr 0x40) and push 4 stores -> st_ready=0 with count=4 and the 5th store is not accepted; drop ld_valid -> entries drain in push order at 1 per cycle.
- Overlap stall:
  - Queue sb at 0x23, then load lw at 0x20 -> ld_stall=1 and mem_write=1 in the same cycle; the next cycle ld_stall=0.
  - Load lw at 0x24 instead -> ld_stall=0, mem_write=0 (load owns the port).
- Halfword boundary: queue sh at 0x31 (bytes 0x31-0x32), load lbu at 0x33 -> no stall; load lb at 0x32 -> stall.
- Wrap and simultaneous events:
  - Push 6 stores over time with concurrent drains; pointers wrap past DEPTH-1 and memory receives all 6 in order.
  - Span at 0xFFFFFFFE (sw) vs load at 0x00000000 -> no stall.
